// File: rtl/regfile_wb_arbiter.sv
// Purpose : merges two writeback sources into one register-file write per cycle, in order, with no lost writes.
// Latency : 1 cycle from accepted write (empty queue) to o_we_out; queued writes drain one per cycle.
// Backpr. : o_ready drops when occupancy > DEPTH-2; a source holding valid while o_ready=0 is not accepted.
//
// Ports:
//   i_clk, i_rst                        clock, asynchronous active-high reset
//   i_valid_a/i_addr_a/i_data_a         pipe A writeback
//   i_valid_b/i_addr_b/i_data_b         pipe B writeback (younger than A in the same cycle)
//   o_ready                             both sources may transfer this cycle
//   o_we_out/o_addr_out/o_wd_out        register-file write port (WE3/ADDR3/WD3)
//   o_pending                           queue occupancy
//   o_idle                              queue empty and no write on the port
//   i_lookup_addr/o_hit/o_hit_data      forwarding lookup, present only with WB_BYPASS_EN defined
//
// Optional feature macro: WB_BYPASS_EN

module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid_a,
    input  logic [ADDR_WIDTH-1:0]        i_addr_a,
    input  logic [DATA_WIDTH-1:0]        i_data_a,
    input  logic                         i_valid_b,
    input  logic [ADDR_WIDTH-1:0]        i_addr_b,
    input  logic [DATA_WIDTH-1:0]        i_data_b,
    output logic                         o_ready,
    output logic                         o_we_out,
    output logic [ADDR_WIDTH-1:0]        o_addr_out,
    output logic [DATA_WIDTH-1:0]        o_wd_out,
    output logic [$clog2(DEPTH+1)-1:0]   o_pending,
    output logic                         o_idle
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_WIDTH-1:0]        i_lookup_addr,
    output logic                         o_hit,
    output logic [DATA_WIDTH-1:0]        o_hit_data
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH-2);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    // Queue is kept as a shift register: entry 0 is the oldest (head).
    wr_t                   r_q [DEPTH];
    logic [CW-1:0]         r_count;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wd;

    wr_t                   w_q_nxt [DEPTH];
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_ready;
    logic                  w_a_acc;
    logic                  w_b_acc;
    logic                  w_pop;
    logic                  w_out_vld;
    wr_t                   w_out;
    wr_t                   w_wr_a;
    wr_t                   w_wr_b;

    assign w_ready = (r_count <= RDY_MAX);

    // Writes to x0 are consumed here and never reach the queue or the port.
    assign w_a_acc = i_valid_a && w_ready && (i_addr_a != '0);
    assign w_b_acc = i_valid_b && w_ready && (i_addr_b != '0);
    assign w_pop   = (r_count != '0);
    assign w_wr_a  = '{addr: i_addr_a, data: i_data_a};
    assign w_wr_b  = '{addr: i_addr_b, data: i_data_b};

    // Candidate order each cycle: queued entries (oldest first), then A, then B.
    // The first candidate goes to the port; the rest are appended in order.
    always_comb begin
        w_out     = '0;
        w_out_vld = 1'b0;
        w_q_nxt   = r_q;
        w_cnt_nxt = r_count;

        if (w_pop) begin
            w_out     = r_q[0];
            w_out_vld = 1'b1;
            for (int i = 0; i < DEPTH-1; i++) begin
                w_q_nxt[i] = r_q[i+1];
            end
            w_cnt_nxt = r_count - CW'(1);
        end else if (w_a_acc) begin
            w_out     = w_wr_a;
            w_out_vld = 1'b1;
        end else if (w_b_acc) begin
            w_out     = w_wr_b;
            w_out_vld = 1'b1;
        end

        // A is appended only when the queue head took the port slot.
        if (w_pop && w_a_acc) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == w_cnt_nxt) w_q_nxt[i] = w_wr_a;
            end
            w_cnt_nxt = w_cnt_nxt + CW'(1);
        end

        // B is appended whenever something older than it took the port slot.
        if (w_b_acc && (w_pop || w_a_acc)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == w_cnt_nxt) w_q_nxt[i] = w_wr_b;
            end
            w_cnt_nxt = w_cnt_nxt + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wd    <= '0;
        end else begin
            r_q     <= w_q_nxt;
            r_count <= w_cnt_nxt;
            r_we    <= w_out_vld;
            // Address/data hold their last value when nothing is written.
            if (w_out_vld) begin
                r_addr <= w_out.addr;
                r_wd   <= w_out.data;
            end
        end
    end

    assign o_ready    = w_ready;
    assign o_we_out   = r_we;
    assign o_addr_out = r_addr;
    assign o_wd_out   = r_wd;
    assign o_pending  = r_count;
    assign o_idle     = (r_count == '0) && !r_we;

`ifdef WB_BYPASS_EN
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_hit_data;

    // Scan oldest to youngest so the last match (queue tail side) wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        if (i_lookup_addr != '0) begin
            if (r_we && (r_addr == i_lookup_addr)) begin
                w_hit      = 1'b1;
                w_hit_data = r_wd;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < r_count) && (r_q[i].addr == i_lookup_addr)) begin
                    w_hit      = 1'b1;
                    w_hit_data = r_q[i].data;
                end
            end
        end
    end

    assign o_hit      = w_hit;
    assign o_hit_data = w_hit_data;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writer-side front end for the dual-write-port register file. Accepts retiring results from two writeback sources (pipe A, pipe B) and serialises them into one register-file write per cycle. No write is ever lost, which the file's WE3-over-WE6 priority would otherwise cause. Buffers surplus writes in a small in-order queue and back-pressures both sources when the queue is near full. Drives the register file's ADDR3/WD3/WE3 port; WE6 is tied low at the top level.

Parameters:
ADDR_WIDTH, 5, register address width
DATA_WIDTH, 32, register data width
DEPTH, 4, pending-write queue entries (>=2)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous reset, active-high
valid_a  input  1  pipe A presents a write
addr_a  input  ADDR_WIDTH  pipe A destination register
data_a  input  DATA_WIDTH  pipe A write data
valid_b  input  1  pipe B presents a write
addr_b  input  ADDR_WIDTH  pipe B destination register
data_b  input  DATA_WIDTH  pipe B write data
ready  output  1  both sources may transfer this cycle
we_out  output  1  register-file write enable (to WE3)
addr_out  output  ADDR_WIDTH  register-file write address (to ADDR3)
wd_out  output  DATA_WIDTH  register-file write data (to WD3)
pending  output  $clog2(DEPTH+1)  queue occupancy
idle  output  1  queue empty and we_out low

Behaviour:
- Reset (async, immediate): queue cleared, count=0, we_out=0, addr_out=0, wd_out=0, pending=0, idle=1, ready=1. Reset mid-operation discards all queued and in-flight writes; nothing is emitted after the reset edge.
- ready = (count <= DEPTH-2), combinational from registered count. It is independent of valid_a/valid_b.
- Transfer: source X transfers when valid_X && ready. valid_X while ready=0 is ignored; the source must hold its write.
- x0 filter: a transferred write with addr==0 is accepted and discarded. It never enters the queue or the output.
- Ordering per cycle: candidate list = queue head..tail (oldest first), then A, then B. A is older than B when both arrive in the same cycle.
- Posedge update:
  - First candidate loads the output registers with we_out=1.
  - Remaining candidates append to the queue in order.
  - No candidate: we_out=0; addr_out/wd_out hold their last values.
- Latency: a write arriving at an empty queue appears on we_out on the next posedge (1 cycle). The register file commits it on the following negedge.
- Throughput: 1 write per cycle out. Net queue growth is at most +1 per cycle, so ready's threshold guarantees no overflow.
- Same address in flight twice: both writes are emitted in order. The younger write lands last. No coalescing.
- count never exceeds DEPTH-1 in normal operation. pending reflects count after each posedge.
- idle = (count==0) && !we_out.

Optional Feature:
WB_BYPASS_EN: adds input lookup_addr[ADDR_WIDTH] and outputs hit (1) and hit_data[DATA_WIDTH]. Lookup is combinational over the output register (while we_out=1) and all valid queue entries.
- hit=1 if any matches and lookup_addr!=0.
- hit_data = youngest matching value: queue tail first, output register last.
- hit=0 and hit_data=0 otherwise.
- Decode uses this to read values not yet committed to the file.
Without the macro: the ports are absent and there is no lookup logic.

Test Plan:
- Single write: valid_a=1, addr_a=5, data_a=0xDEADBEEF for 1 cycle, queue empty -> next cycle we_out=1, addr_out=5, wd_out=0xDEADBEEF. Following cycle we_out=0, idle=1.
- Simultaneous: A(3,0x11) and B(3,0x22) in the same cycle -> we_out on cycles N+1 (3,0x11) and N+2 (3,0x22); pending=1 after N+1.
- x0 filter: A(0,0xFF) with B(7,0x77) -> exactly one write emitted, (7,0x77); nothing is written to address 0.
- Back-pressure (DEPTH=4): both valid every cycle with distinct addresses -> ready drops to 0 once pending=3. Inputs held while ready=0 are ignored. All accepted writes are emitted in A-then-B order with no loss or duplication.
- Reset mid-burst: assert rst with pending=2 and we_out=1 -> we_out, pending and addr_out go to 0 immediately. No further writes after release.
- WB_BYPASS_EN: queue holds (9,0xA) then (9,0xB); lookup_addr=9 -> hit=1, hit_data=0xB. lookup_addr=0 -> hit=0.
